// File: rtl/data_to_axi_packer.sv
// data_to_axi_packer
// Packs a stream of single elements into AXI4-Stream beats of NUM_ELEMENTS lanes.
// Lanes fill from lane 0 upward. A beat is emitted when the top lane fills or
// when an element carries last. Lanes above a last element carry zero keep.
// The output beat is fully registered. Elements that do not complete a beat are
// always accepted. An element that completes a beat waits only when the output
// register is still occupied.
module data_to_axi_packer #(
   parameter type data_t       = logic [31:0],
   parameter int  AXI_WIDTH    = 512,
   parameter int  DATA_WIDTH   = $bits(data_t),
   parameter int  NUM_ELEMENTS = AXI_WIDTH / DATA_WIDTH
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [DATA_WIDTH-1:0]  in_data,
   input  logic                   in_keep,
   input  logic                   in_last,
   input  logic                   in_valid,
   output logic                   in_ready,
   output logic [AXI_WIDTH-1:0]   out_tdata,
   output logic [AXI_WIDTH/8-1:0] out_tkeep,
   output logic                   out_tlast,
   output logic                   out_tvalid,
   input  logic                   out_tready
);

   localparam int CNT_W      = $clog2(NUM_ELEMENTS);
   localparam int LANE_BYTES = DATA_WIDTH / 8;
   localparam logic [CNT_W-1:0] TOP_LANE = CNT_W'(NUM_ELEMENTS - 1);

   if (AXI_WIDTH != DATA_WIDTH * NUM_ELEMENTS) begin : g_bad_axi_width
      $error("data_to_axi_packer: AXI_WIDTH must equal DATA_WIDTH * NUM_ELEMENTS");
   end
   if (DATA_WIDTH % 8 != 0) begin : g_bad_data_width
      $error("data_to_axi_packer: DATA_WIDTH must be a whole number of bytes");
   end
   if (NUM_ELEMENTS < 2) begin : g_bad_num_elements
      $error("data_to_axi_packer: NUM_ELEMENTS must be at least 2");
   end

   // Next lane to fill
   logic [CNT_W-1:0]       cnt;

   // Assembly register. The top lane is never stored here: the element that
   // lands in it always completes the beat and goes straight to the output.
   logic [DATA_WIDTH-1:0]  asm_data [NUM_ELEMENTS-1];
   logic [NUM_ELEMENTS-2:0] asm_keep;

   // Beat being assembled for the output register
   logic [AXI_WIDTH-1:0]   beat_data;
   logic [NUM_ELEMENTS-1:0] beat_lane_keep;
   logic [AXI_WIDTH/8-1:0] beat_keep;

   logic top_lane;
   logic out_free;
   logic accept;
   logic complete;

   assign top_lane = (cnt == TOP_LANE);
   assign out_free = !out_tvalid || out_tready;
   // Only an element that completes a beat needs the output slot, so only it
   // can be held off. Deliberately independent of in_valid.
   assign in_ready = out_free || (!top_lane && !in_last);
   assign accept   = in_valid && in_ready;
   assign complete = accept && (top_lane || in_last);

   // Merge stored lanes below cnt with the incoming element at lane cnt; zero above
   always_comb begin
      beat_data      = '0;
      beat_lane_keep = '0;
      for (int i = 0; i < NUM_ELEMENTS - 1; i++) begin
         if (i < int'(cnt)) begin
            beat_data[i*DATA_WIDTH +: DATA_WIDTH] = asm_data[i];
            beat_lane_keep[i]                     = asm_keep[i];
         end
      end
      for (int i = 0; i < NUM_ELEMENTS; i++) begin
         if (i == int'(cnt)) begin
            beat_data[i*DATA_WIDTH +: DATA_WIDTH] = in_data;
            beat_lane_keep[i]                     = in_keep;
         end
      end
   end

   // Widen the per-lane keep bit to every byte of that lane
   always_comb begin
      beat_keep = '0;
      for (int i = 0; i < NUM_ELEMENTS; i++) begin
         beat_keep[i*LANE_BYTES +: LANE_BYTES] = {LANE_BYTES{beat_lane_keep[i]}};
      end
   end

   // Lane counter: advance on each accept, return to lane 0 when a beat completes
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (complete) begin
         cnt <= '0;
      end else if (accept) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   // Assembly data: capture non-completing elements into their lane (no reset needed)
   always_ff @(posedge clk) begin
      if (accept && !complete) begin
         for (int i = 0; i < NUM_ELEMENTS - 1; i++) begin
            if (cnt == CNT_W'(i)) begin
               asm_data[i] <= in_data;
            end
         end
      end
   end

   // Assembly keep bits: capture per lane, wiped when a beat completes or on reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         asm_keep <= '0;
      end else if (complete) begin
         asm_keep <= '0;
      end else if (accept) begin
         for (int i = 0; i < NUM_ELEMENTS - 1; i++) begin
            if (cnt == CNT_W'(i)) begin
               asm_keep[i] <= in_keep;
            end
         end
      end
   end

   // Output register: load on completion (even while draining), else drop valid on handshake
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_tdata  <= '0;
         out_tkeep  <= '0;
         out_tlast  <= 1'b0;
         out_tvalid <= 1'b0;
      end else if (complete) begin
         out_tdata  <= beat_data;
         out_tkeep  <= beat_keep;
         out_tlast  <= in_last;
         out_tvalid <= 1'b1;
      end else if (out_tready) begin
         out_tvalid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_data_to_axi_packer.sv
// Testbench for data_to_axi_packer: 32-bit elements, 128-bit beats (4 lanes).
// A reference model collects accepted elements into packets and predicts every
// output beat; directed scenarios add explicit expected beat values.
module tb_data_to_axi_packer;

   localparam int AXI_W = 128;
   localparam int DW    = 32;
   localparam int NE    = 4;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [DW-1:0]    in_data;
   logic             in_keep;
   logic             in_last;
   logic             in_valid;
   logic             in_ready;
   logic [AXI_W-1:0] out_tdata;
   logic [15:0]      out_tkeep;
   logic             out_tlast;
   logic             out_tvalid;
   logic             out_tready;

   int checks   = 0;
   int failures = 0;
   int stall_cnt;
   bit mon_en   = 1'b0;
   bit rdy_rand = 1'b0;

   typedef struct {
      logic [AXI_W-1:0] d;
      logic [15:0]      k;
      logic             l;
   } beat_t;

   beat_t         exp_q[$];
   logic [DW-1:0] mdat [NE];
   logic          mkeep[NE];
   int            mn = 0;

   data_to_axi_packer #(
      .data_t    (logic [31:0]),
      .AXI_WIDTH (AXI_W)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_data    (in_data),
      .in_keep    (in_keep),
      .in_last    (in_last),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .out_tdata  (out_tdata),
      .out_tkeep  (out_tkeep),
      .out_tlast  (out_tlast),
      .out_tvalid (out_tvalid),
      .out_tready (out_tready)
   );

   initial forever #5 clk = ~clk;

   task automatic chk(input string tag, input logic [AXI_W-1:0] got, input logic [AXI_W-1:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // Reference model: store an accepted element; a full or last-terminated
   // packet chunk becomes one expected beat.
   task automatic model_push(input logic [DW-1:0] d, input logic k, input logic l);
      beat_t b;
      mdat[mn]  = d;
      mkeep[mn] = k;
      mn++;
      if (mn == NE || l) begin
         b.d = '0;
         b.k = '0;
         b.l = l;
         for (int j = 0; j < mn; j++) begin
            b.d = b.d | (AXI_W'(mdat[j]) << (DW * j));
            if (mkeep[j]) b.k = b.k | (16'h000F << (4 * j));
         end
         exp_q.push_back(b);
         mn = 0;
      end
   endtask

   // Monitor on the falling edge: compare outputs with the model, then apply
   // the handshakes that the next rising edge will perform.
   always @(negedge clk) begin
      logic exp_rdy;
      if (mon_en) begin
         exp_rdy = (exp_q.size() == 0 || out_tready) || (mn != NE - 1 && !in_last);
         chk("in_ready", AXI_W'(in_ready), AXI_W'(exp_rdy));
         chk("tvalid", AXI_W'(out_tvalid), AXI_W'(exp_q.size() != 0));
         if (exp_q.size() != 0 && out_tvalid) begin
            chk("tdata", out_tdata, exp_q[0].d);
            chk("tkeep", AXI_W'(out_tkeep), AXI_W'(exp_q[0].k));
            chk("tlast", AXI_W'(out_tlast), AXI_W'(exp_q[0].l));
         end
         if (!rst_n) begin
            exp_q.delete();
            mn = 0;
         end else begin
            if (out_tvalid && out_tready && exp_q.size() != 0) void'(exp_q.pop_front());
            if (in_valid && in_ready) model_push(in_data, in_keep, in_last);
         end
      end
   end

   // Random backpressure when enabled
   initial forever begin
      @(posedge clk);
      #1;
      if (rdy_rand) out_tready = ($urandom_range(0, 3) != 0);
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Present one element and hold it until accepted (bounded wait)
   task automatic send(input logic [DW-1:0] d, input logic k, input logic l);
      int n;
      bit acc;
      in_data  = d;
      in_keep  = k;
      in_last  = l;
      in_valid = 1'b1;
      n   = 0;
      acc = 1'b0;
      while (!acc && n < 200) begin
         @(negedge clk);
         acc = in_ready;
         if (!acc) stall_cnt++;
         n++;
         @(posedge clk);
         #1;
      end
      if (!acc) chk("send_timeout", AXI_W'(0), AXI_W'(1));
   endtask

   initial begin
      rst_n      = 1'b0;
      in_data    = '0;
      in_keep    = 1'b0;
      in_last    = 1'b0;
      in_valid   = 1'b0;
      out_tready = 1'b1;
      stall_cnt  = 0;
      idle(3);
      rst_n  = 1'b1;
      mon_en = 1'b1;

      // Reset state
      @(negedge clk);
      chk("rst_tvalid", AXI_W'(out_tvalid), AXI_W'(0));
      chk("rst_tdata", out_tdata, AXI_W'(0));
      chk("rst_tkeep", AXI_W'(out_tkeep), AXI_W'(0));
      chk("rst_tlast", AXI_W'(out_tlast), AXI_W'(0));
      @(posedge clk);
      #1;

      // Eight elements back to back, last on 7
      stall_cnt = 0;
      for (int i = 0; i < 8; i++) send(DW'(i), 1'b1, i == 7);
      in_valid = 1'b0;
      @(negedge clk);
      chk("b2b_tdata", out_tdata, 128'h00000007_00000006_00000005_00000004);
      chk("b2b_tkeep", AXI_W'(out_tkeep), AXI_W'(16'hFFFF));
      chk("b2b_tlast", AXI_W'(out_tlast), AXI_W'(1));
      chk("b2b_no_stall", AXI_W'(stall_cnt), AXI_W'(0));
      idle(2);

      // Short packet: six elements, then a lone element lands in lane 0
      for (int i = 0; i < 6; i++) send(DW'(i), 1'b1, i == 5);
      in_valid = 1'b0;
      @(negedge clk);
      chk("short_tdata", out_tdata, 128'h00000000_00000000_00000005_00000004);
      chk("short_tkeep", AXI_W'(out_tkeep), AXI_W'(16'h00FF));
      idle(1);
      send(DW'(9), 1'b1, 1'b1);
      in_valid = 1'b0;
      @(negedge clk);
      chk("next_lane0", out_tdata, AXI_W'(9));
      idle(2);

      // Single element packet
      send(DW'(32'hAB), 1'b1, 1'b1);
      in_valid = 1'b0;
      @(negedge clk);
      chk("single_tdata", out_tdata, AXI_W'(32'hAB));
      chk("single_tkeep", AXI_W'(out_tkeep), AXI_W'(16'h000F));
      chk("single_tlast", AXI_W'(out_tlast), AXI_W'(1));
      idle(2);

      // Null element in lane 2
      for (int i = 0; i < 4; i++) send(DW'(i), i != 2, 1'b0);
      in_valid = 1'b0;
      @(negedge clk);
      chk("null_tkeep", AXI_W'(out_tkeep), AXI_W'(16'hF0FF));
      chk("null_tdata", out_tdata, 128'h00000003_00000002_00000001_00000000);
      idle(2);

      // Backpressure: 0..6 go in, element 7 is held off while the beat waits
      out_tready = 1'b0;
      for (int i = 0; i < 7; i++) send(DW'(i), 1'b1, 1'b0);
      in_data  = DW'(7);
      in_keep  = 1'b1;
      in_last  = 1'b0;
      in_valid = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         chk("stall_ready", AXI_W'(in_ready), AXI_W'(0));
         chk("stall_hold", out_tdata, 128'h00000003_00000002_00000001_00000000);
      end
      @(posedge clk);
      #1;
      out_tready = 1'b1;
      @(negedge clk);
      chk("release_ready", AXI_W'(in_ready), AXI_W'(1));
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(negedge clk);
      chk("release_tvalid", AXI_W'(out_tvalid), AXI_W'(1));
      chk("release_tdata", out_tdata, 128'h00000007_00000006_00000005_00000004);
      idle(2);

      // Reset with a partial beat pending
      send(DW'(32'h11), 1'b1, 1'b0);
      send(DW'(32'h22), 1'b1, 1'b0);
      in_valid = 1'b0;
      rst_n    = 1'b0;
      idle(2);
      @(negedge clk);
      chk("midrst_tvalid", AXI_W'(out_tvalid), AXI_W'(0));
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) send(DW'(i), 1'b1, 1'b0);
      in_valid = 1'b0;
      @(negedge clk);
      chk("postrst_tdata", out_tdata, 128'h00000003_00000002_00000001_00000000);
      idle(2);

      // Random traffic under random backpressure
      rdy_rand = 1'b1;
      for (int e = 0; e < 400; e++) begin
         in_valid = 1'b0;
         idle($urandom_range(0, 2));
         send($urandom, $urandom_range(0, 7) != 0, $urandom_range(0, 5) == 0);
      end
      in_valid = 1'b0;
      rdy_rand = 1'b0;
      out_tready = 1'b1;
      idle(4);
      chk("drain", AXI_W'(exp_q.size()), AXI_W'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
